// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder
// Bounded-latency responder for the picorv32 native memory bus, backed by a
// small word RAM. A stall input can insert up to MAX_WAIT wait cycles per
// request. A sticky fault flag records native-bus protocol violations.
module picorv32_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        stall,
    output logic        fault,
    output logic [15:0] req_count
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, next_state;

    logic [7:0]           cnt;
    logic [31:0]          cap_addr;
    logic [31:0]          cap_wdata;
    logic [3:0]           cap_wstrb;
    logic                 cap_instr;
    logic [ADDR_BITS-1:0] cap_idx;

    logic capture;
    logic hold_wait;
    logic commit;
    logic violation;

    // The RAM has no reset; it only starts out as all zeros.
    logic [31:0] ram [DEPTH] = '{default: '0};

    assign cap_idx = cap_addr[ADDR_BITS+1:2];

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, handshake strobes and protocol-violation detection.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        hold_wait  = 1'b0;
        commit     = 1'b0;
        violation  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    capture    = 1'b1;
                    next_state = WAIT;
                    if (mem_addr[1:0] != 2'b00) begin
                        violation = 1'b1;
                    end
                    if (!(mem_wstrb inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                            4'b1000, 4'b0011, 4'b1100, 4'b1111})) begin
                        violation = 1'b1;
                    end
                end
            end
            WAIT: begin
                hold_wait = stall && (cnt < 8'(MAX_WAIT));
                if (!hold_wait) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if ((state == WAIT) || (state == RESP)) begin
            if (!mem_valid || (mem_addr != cap_addr) || (mem_wdata != cap_wdata) ||
                (mem_wstrb != cap_wstrb) || (mem_instr != cap_instr)) begin
                violation = 1'b1;
            end
        end
    end

    // Request capture, wait counter, response outputs, fault flag and handshake count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 8'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_wstrb <= 4'd0;
            cap_instr <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            fault     <= 1'b0;
            req_count <= 16'd0;
        end else begin
            mem_ready <= commit;
            if (capture) begin
                cap_addr  <= mem_addr;
                cap_wdata <= mem_wdata;
                cap_wstrb <= mem_wstrb;
                cap_instr <= mem_instr;
                cnt       <= 8'd0;
            end else if (hold_wait) begin
                cnt <= cnt + 8'd1;
            end
            if (commit) begin
                mem_rdata <= ram[cap_idx];
            end
            if (state == RESP) begin
                req_count <= req_count + 16'd1;
            end
            if (violation) begin
                fault <= 1'b1;
            end
        end
    end

    // Byte-masked RAM write on the commit edge, using the captured request.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (cap_wstrb[k]) begin
                    ram[cap_idx][8*k +: 8] <= cap_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Testbench for picorv32_mem_responder: directed scenarios plus randomized
// requests checked against a word-array reference model.
module tb_picorv32_mem_responder;

    localparam int ADDR_BITS = 8;
    localparam int MAX_WAIT  = 4;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        fault;
    logic [15:0] req_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_ram [DEPTH];
    logic        model_fault;
    logic [15:0] model_count;

    picorv32_mem_responder #(
        .ADDR_BITS(ADDR_BITS),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .stall    (stall),
        .fault    (fault),
        .req_count(req_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit strobe_legal(input logic [3:0] s);
        return s inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                         4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        mem_valid = 1'b0;
        stall     = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        model_fault = 1'b0;
        model_count = 16'd0;
    endtask

    task automatic go_idle();
        @(negedge clk);
        mem_valid = 1'b0;
        stall     = 1'b0;
    endtask

    // One complete request. stall_mask bit j is the stall level during the
    // j-th wait cycle; glitch changes mem_addr during the first wait cycle.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [7:0] stall_mask, input bit glitch,
                                 input logic [31:0] glitch_addr);
        logic [31:0] exp_rdata;
        int          idx;
        int          n;
        int          lat;
        int          exp_lat;
        bit          done;
        idx       = int'(addr[ADDR_BITS+1:2]);
        exp_rdata = model_ram[idx];
        n = 0;
        while (n < MAX_WAIT && stall_mask[n]) n++;
        exp_lat = 2 + n;
        if (addr[1:0] != 2'b00 || !strobe_legal(wstrb) || glitch) model_fault = 1'b1;

        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = 1'($urandom_range(0, 1));
        stall     = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_ready) begin
                done = 1'b1;
            end else begin
                stall = (lat <= 8) ? stall_mask[lat-1] : 1'b0;
                if (glitch && lat == 1) mem_addr = glitch_addr;
            end
        end
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_rdata"}, mem_rdata, exp_rdata);

        for (int k = 0; k < 4; k++) begin
            if (wstrb[k]) model_ram[idx][8*k +: 8] = wdata[8*k +: 8];
        end
        model_count = model_count + 16'd1;
        stall = 1'b0;

        @(posedge clk);
        #1;
        checkOutput({tag, "_ready_drop"}, 32'(mem_ready), 32'd0);
        checkOutput({tag, "_rdata_hold"}, mem_rdata, exp_rdata);
        checkOutput({tag, "_count"}, 32'(req_count), 32'(model_count));
        checkOutput({tag, "_fault"}, 32'(fault), 32'(model_fault));
    endtask

    initial begin
        logic [3:0]  legal [8];
        logic [31:0] addr;
        legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int i = 0; i < DEPTH; i++) model_ram[i] = 32'd0;
        model_fault = 1'b0;
        model_count = 16'd0;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        stall     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(mem_ready), 32'd0);
        checkOutput("reset_rdata", mem_rdata, 32'd0);
        checkOutput("reset_fault", 32'(fault), 32'd0);
        checkOutput("reset_count", 32'(req_count), 32'd0);
        reset = 1'b0;

        // Full-word write then read-back, no stalls.
        applyStimulus("wr_word", 32'h10, 32'hDEADBEEF, 4'b1111, 8'h00, 1'b0, 32'h0);
        applyStimulus("rd_word", 32'h10, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);
        // Byte write returns the old word; read shows the merged word.
        applyStimulus("wr_byte", 32'h10, 32'h0000AA00, 4'b0010, 8'h00, 1'b0, 32'h0);
        applyStimulus("rd_byte", 32'h10, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);
        checkOutput("merged_word", model_ram[4], 32'hDEADAAEF);
        // Stall held throughout is capped; a two-cycle stall adds two cycles.
        applyStimulus("stall_max", 32'h14, 32'h0, 4'b0000, 8'hFF, 1'b0, 32'h0);
        applyStimulus("stall_two", 32'h14, 32'h0, 4'b0000, 8'b0000_0011, 1'b0, 32'h0);
        // High address bits alias onto the same RAM word.
        applyStimulus("alias_wr", 32'h400, 32'h12345678, 4'b1111, 8'h00, 1'b0, 32'h0);
        applyStimulus("alias_rd", 32'h000, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);
        go_idle();

        // Randomized traffic with legal requests, idle gaps and stalls.
        for (int i = 0; i < 40; i++) begin
            addr = {$urandom_range(0, 15) << (ADDR_BITS + 2)};
            addr = addr | (32'($urandom_range(0, 15)) << 2);
            applyStimulus("rand", addr, $urandom, legal[$urandom_range(0, 7)],
                          8'($urandom), 1'b0, 32'h0);
            if ($urandom_range(0, 3) == 0) go_idle();
        end

        // Address changes during WAIT: fault, access still lands at 0x20.
        go_idle();
        applyStimulus("glitch_wr", 32'h20, 32'hCAFEF00D, 4'b1111, 8'h00, 1'b1, 32'h24);
        applyStimulus("glitch_rd20", 32'h20, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);
        applyStimulus("glitch_rd24", 32'h24, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);

        // Reset while a write waits in WAIT: write discarded, state cleared.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h10;
        mem_wdata = 32'hFFFFFFFF;
        mem_wstrb = 4'b1111;
        mem_instr = 1'b0;
        stall     = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("rst_wait_ready", 32'(mem_ready), 32'd0);
        checkOutput("rst_wait_fault", 32'(fault), 32'd0);
        checkOutput("rst_wait_count", 32'(req_count), 32'd0);
        mem_valid = 1'b0;
        stall     = 1'b0;
        model_fault = 1'b0;
        model_count = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("rst_wait_rd", 32'h10, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);

        // Misaligned address and illegal strobe pattern, each from reset.
        do_reset();
        applyStimulus("misaligned", 32'h13, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);
        do_reset();
        applyStimulus("bad_strobe", 32'h30, 32'h00BBCC00, 4'b0110, 8'h00, 1'b0, 32'h0);
        applyStimulus("bad_strobe_rd", 32'h30, 32'h0, 4'b0000, 8'h00, 1'b0, 32'h0);
        go_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_responder.md
Name: picorv32_mem_responder

Overview:
Bounded-latency memory responder for the picorv32 native memory interface. It consumes mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_instr and produces mem_ready/mem_rdata from a small internal word RAM. A solver- or bench-driven stall input inserts wait states up to a fixed bound. A sticky fault flag reports native-bus protocol violations, so formal harnesses can constrain on or assert against it.

Parameters:
ADDR_BITS, 8, RAM depth is 2**ADDR_BITS 32-bit words; address index = mem_addr[ADDR_BITS+1:2].
MAX_WAIT, 4, maximum number of stall-inserted wait cycles per request (0..255).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
mem_valid  input  1  request valid from core.
mem_instr  input  1  request is an instruction fetch (captured and checked only).
mem_addr  input  32  byte address.
mem_wdata  input  32  write data.
mem_wstrb  input  4  byte write strobes; 0000 = read.
mem_ready  output  1  one-cycle completion pulse.
mem_rdata  output  32  read data, valid while mem_ready=1.
stall  input  1  request for one extra wait cycle, honoured only in WAIT.
fault  output  1  sticky protocol-violation flag.
req_count  output  16  number of completed handshakes.

Behaviour:
- Reset (async, immediate): state=IDLE, mem_ready=0, mem_rdata=0, fault=0, req_count=0, wait counter=0, captured request regs=0.
  - RAM is not reset; it is zero-initialised at time 0 only.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if mem_valid=1, capture addr/wdata/wstrb/instr and go to WAIT with cnt=0. Otherwise stay.
- WAIT, stall=1 and cnt<MAX_WAIT: cnt<=cnt+1, stay in WAIT.
- WAIT, otherwise: commit the access on this edge.
  - mem_rdata <= RAM[idx], the pre-write contents, for reads and writes alike.
  - For each byte k with wstrb[k]=1: RAM[idx][8k+7:8k] <= wdata byte k.
  - mem_ready <= 1; go to RESP.
- RESP: mem_ready=1 for exactly this cycle; req_count increments; next state IDLE with mem_ready<=0.
  - mem_rdata holds its value until the next commit.
- Latency: request first seen in IDLE at cycle t gives mem_ready high at cycle t+2+n, where n = stall-inserted cycles, 0<=n<=MAX_WAIT. Max latency = 2+MAX_WAIT.
- Back-to-back: a request present in the cycle after RESP is accepted from IDLE normally. No request is accepted while in WAIT or RESP.
- Address aliasing: bits above ADDR_BITS+1 are ignored. Out-of-range addresses wrap and raise no fault.
- Fault conditions, checked every cycle; fault is set on the next edge and stays 1 until reset:
  - at capture, mem_addr[1:0] != 0;
  - at capture, mem_wstrb not in {0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111};
  - in WAIT or RESP, mem_valid=0;
  - in WAIT or RESP, any of mem_addr/mem_wdata/mem_wstrb/mem_instr differs from its captured value.
  - A faulting request still completes normally, using the captured values.
- req_count wraps 0xFFFF -> 0x0000.
- Reset mid-operation: reset in WAIT discards the pending access, so RAM is unchanged. Reset in RESP keeps the already-committed write, but req_count is cleared.
- Simultaneous stall=1 with cnt==MAX_WAIT: stall is ignored and the commit proceeds.

Test Plan:
1. ADDR_BITS=8, stall=0. Write 0xDEADBEEF to 0x10 with wstrb=1111, valid first seen at t -> mem_ready=1 only at t+2, req_count=1. Read 0x10 -> mem_rdata=0xDEADBEEF at its ready cycle.
2. Byte write: wstrb=0010, wdata=0x0000AA00 to 0x10 -> mem_rdata on that write = 0xDEADBEEF (old word). A subsequent read returns 0xDEADAAEF.
3. MAX_WAIT=4, stall held 1 throughout -> mem_ready exactly at t+6. With stall high for 2 cycles then 0 -> mem_ready at t+4.
4. Protocol violations:
   - mem_addr changes from 0x20 to 0x24 during WAIT -> fault=1 next cycle; the access completes at 0x20 and fault stays 1 through later clean requests.
   - Separately, from reset, a request at 0x13 -> fault=1.
   - Separately, wstrb=0110 -> fault=1.
5. Aliasing: write 0x12345678 to 0x400, read 0x000 -> 0x12345678.
6. Reset in WAIT of a write of 0xFFFFFFFF to 0x10 -> mem_ready=0 immediately. After reset, a read of 0x10 returns the old value and fault=0, req_count=0.
